// File: rtl/winner_queue.sv
// winner_queue: small in-order FIFO that buffers winners coming out of an
// upstream binary aggregator. The aggregator cannot be stalled, so a winner
// that finds the queue full (and no pop in the same cycle) is dropped and
// accounted for in a sticky overflow flag and a saturating drop counter.
// Optionally, a winner whose key repeats the last accepted key is discarded.
//
// Output handshake: out_vld/out_key/out_data describe the queue head and are
// held stable until the consumer takes it; a transfer (pop) happens on a rising
// clk edge where out_vld=1 and out_rdy=1. out_rdy has no effect while out_vld=0,
// and out_vld never depends on out_rdy.
module winner_queue #(
  parameter int KEY_WIDTH  = 6,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int DROP_DUP   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    winner_vld,
  input  logic [KEY_WIDTH-1:0]    winner_key,
  input  logic [DATA_WIDTH-1:0]   winner_data,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [KEY_WIDTH-1:0]    out_key,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [$clog2(DEPTH):0]  fill_cnt,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow,
  output logic [7:0]              drop_cnt,
  input  logic                    ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = KEY_WIDTH + DATA_WIDTH;

  // Storage holds {key, data}; it is deliberately not reset, validity is
  // tracked purely by fill_cnt and the pointers.
  logic [EW-1:0]        mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [KEY_WIDTH-1:0] last_key;
  logic                 last_key_vld;

  logic                 pop;
  logic                 dup;
  logic                 room;
  logic                 push;
  logic                 drop;
  logic [EW-1:0]        head;

  // Status flags derive from the occupancy counter only.
  assign full    = (fill_cnt == CW'(DEPTH));
  assign empty   = (fill_cnt == '0);
  assign out_vld = !empty;

  // A pop frees a slot in the same cycle, so a full queue can still accept.
  assign pop  = out_vld && out_rdy;
  // Duplicate suppression is decided first; a suppressed winner never
  // reaches the full check and therefore never counts as a drop.
  assign dup  = (DROP_DUP != 0) && last_key_vld && (winner_key == last_key);
  assign room = !full || pop;
  assign push = winner_vld && !dup && room;
  assign drop = winner_vld && !dup && !room;

  // Head is read combinationally; outputs are zeroed while nothing is queued
  // so stale or uninitialised storage never leaks out.
  assign head     = mem[rd_ptr];
  assign out_key  = empty ? '0 : head[EW-1:DATA_WIDTH];
  assign out_data = empty ? '0 : head[DATA_WIDTH-1:0];

  // Entry storage: write the accepted winner at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {winner_key, winner_data};
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fill_cnt <= fill_cnt + CW'(1);
        2'b01:   fill_cnt <= fill_cnt - CW'(1);
        default: fill_cnt <= fill_cnt;
      endcase
    end
  end

  // Loss accounting: clear wins over a drop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Remember the key of the most recently accepted winner for dedup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_key     <= '0;
      last_key_vld <= 1'b0;
    end else if (push) begin
      last_key     <= winner_key;
      last_key_vld <= 1'b1;
    end
  end

endmodule

// File: tb/tb_winner_queue.sv
module tb_winner_queue;

  localparam int KW  = 6;
  localparam int DW  = 16;
  localparam int DEP = 4;
  localparam int CW  = $clog2(DEP) + 1;

  typedef logic [KW+DW-1:0] ent_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic          winner_vld;
  logic [KW-1:0] winner_key;
  logic [DW-1:0] winner_data;
  logic          out_rdy;
  logic          ovf_clr;

  // instance 0: DROP_DUP=0, instance 1: DROP_DUP=1
  logic          o0_vld, o1_vld;
  logic [KW-1:0] o0_key, o1_key;
  logic [DW-1:0] o0_data, o1_data;
  logic [CW-1:0] o0_fill, o1_fill;
  logic          o0_full, o1_full, o0_empty, o1_empty, o0_ovf, o1_ovf;
  logic [7:0]    o0_drop, o1_drop;

  winner_queue #(.KEY_WIDTH(KW), .DATA_WIDTH(DW), .DEPTH(DEP), .DROP_DUP(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .winner_vld(winner_vld), .winner_key(winner_key),
    .winner_data(winner_data), .out_vld(o0_vld), .out_rdy(out_rdy), .out_key(o0_key),
    .out_data(o0_data), .fill_cnt(o0_fill), .full(o0_full), .empty(o0_empty),
    .overflow(o0_ovf), .drop_cnt(o0_drop), .ovf_clr(ovf_clr)
  );

  winner_queue #(.KEY_WIDTH(KW), .DATA_WIDTH(DW), .DEPTH(DEP), .DROP_DUP(1)) u_dup (
    .clk(clk), .rst_n(rst_n), .winner_vld(winner_vld), .winner_key(winner_key),
    .winner_data(winner_data), .out_vld(o1_vld), .out_rdy(out_rdy), .out_key(o1_key),
    .out_data(o1_data), .fill_cnt(o1_fill), .full(o1_full), .empty(o1_empty),
    .overflow(o1_ovf), .drop_cnt(o1_drop), .ovf_clr(ovf_clr)
  );

  // ---------------- scoreboard / reference model ----------------
  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t exp_q0[$];
  ent_t exp_q1[$];
  logic          m_ovf  [2];
  logic [7:0]    m_drop [2];
  logic [KW-1:0] m_lk   [2];
  logic          m_lkv  [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    for (int m = 0; m < 2; m++) begin
      m_ovf[m]  = 1'b0;
      m_drop[m] = 8'd0;
      m_lk[m]   = '0;
      m_lkv[m]  = 1'b0;
    end
  endtask

  // One clock of the queue's rules: pop the head if the consumer is ready,
  // accept the winner if it is not a duplicate and a slot is (or becomes) free,
  // otherwise count it as lost.
  task automatic model_step(input int m, input logic v, input logic [KW-1:0] k,
                            input logic [DW-1:0] d, input logic r, input logic c);
    int sz;
    bit do_pop, is_dup, accept, lost;
    sz     = (m == 0) ? exp_q0.size() : exp_q1.size();
    do_pop = (sz > 0) && r;
    is_dup = (m == 1) && m_lkv[m] && (k == m_lk[m]);
    accept = v && !is_dup && ((sz < DEP) || do_pop);
    lost   = v && !is_dup && !((sz < DEP) || do_pop);
    if (do_pop) begin
      if (m == 0) void'(exp_q0.pop_front());
      else        void'(exp_q1.pop_front());
    end
    if (accept) begin
      if (m == 0) exp_q0.push_back({k, d});
      else        exp_q1.push_back({k, d});
      m_lk[m]  = k;
      m_lkv[m] = 1'b1;
    end
    if (c) begin
      m_ovf[m]  = 1'b0;
      m_drop[m] = 8'd0;
    end else if (lost) begin
      m_ovf[m] = 1'b1;
      if (m_drop[m] < 8'd255) m_drop[m] = m_drop[m] + 8'd1;
    end
  endtask

  task automatic check_dut(input int m);
    logic          v, f, e, o;
    logic [KW-1:0] k;
    logic [DW-1:0] d;
    logic [CW-1:0] fc;
    logic [7:0]    dc;
    int            sz;
    ent_t          hd;
    if (m == 0) begin
      v = o0_vld; f = o0_full; e = o0_empty; o = o0_ovf; k = o0_key; d = o0_data; fc = o0_fill; dc = o0_drop;
      sz = exp_q0.size(); hd = (sz > 0) ? exp_q0[0] : '0;
    end else begin
      v = o1_vld; f = o1_full; e = o1_empty; o = o1_ovf; k = o1_key; d = o1_data; fc = o1_fill; dc = o1_drop;
      sz = exp_q1.size(); hd = (sz > 0) ? exp_q1[0] : '0;
    end
    check($sformatf("m%0d out_vld", m),  64'(v),  64'(sz != 0));
    check($sformatf("m%0d out_key", m),  64'(k),  64'(hd[KW+DW-1:DW]));
    check($sformatf("m%0d out_data", m), 64'(d),  64'(hd[DW-1:0]));
    check($sformatf("m%0d fill_cnt", m), 64'(fc), 64'(sz));
    check($sformatf("m%0d full", m),     64'(f),  64'(sz == DEP));
    check($sformatf("m%0d empty", m),    64'(e),  64'(sz == 0));
    check($sformatf("m%0d overflow", m), 64'(o),  64'(m_ovf[m]));
    check($sformatf("m%0d drop_cnt", m), 64'(dc), 64'(m_drop[m]));
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive inputs, advance the model, clock, check.
  task automatic cycle(input logic v, input logic [KW-1:0] k, input logic [DW-1:0] d,
                       input logic r, input logic c);
    winner_vld  = v;
    winner_key  = k;
    winner_data = d;
    out_rdy     = r;
    ovf_clr     = c;
    model_step(0, v, k, d, r, c);
    model_step(1, v, k, d, r, c);
    @(posedge clk);
    @(negedge clk);
    check_dut(0);
    check_dut(1);
  endtask

  function automatic logic [DW-1:0] dat_of(input logic [KW-1:0] k);
    return 16'h1000 + DW'(k);
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic          vld;
    logic [KW-1:0] key;
    logic          rdy;
    logic          clr;
    int            e_fill;
    int            e_key;
    int            e_ovf;
    int            e_drop;
  } vec_t;

  vec_t vec[19];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

  initial begin
    // keys 1,2,3 in, then drained in order
    vec[0]  = '{1'b1, 6'd1,  1'b0, 1'b0, 1, 1, 0, 0};
    vec[1]  = '{1'b1, 6'd2,  1'b0, 1'b0, 2, 1, 0, 0};
    vec[2]  = '{1'b1, 6'd3,  1'b0, 1'b0, 3, 1, 0, 0};
    vec[3]  = '{1'b0, 6'd0,  1'b1, 1'b0, 2, 2, 0, 0};
    vec[4]  = '{1'b0, 6'd0,  1'b1, 1'b0, 1, 3, 0, 0};
    vec[5]  = '{1'b0, 6'd0,  1'b1, 1'b0, 0, 0, 0, 0};
    // fill to 4, two drops, clear, clear beats a same-cycle drop
    vec[6]  = '{1'b1, 6'd4,  1'b0, 1'b0, 1, 4, 0, 0};
    vec[7]  = '{1'b1, 6'd5,  1'b0, 1'b0, 2, 4, 0, 0};
    vec[8]  = '{1'b1, 6'd6,  1'b0, 1'b0, 3, 4, 0, 0};
    vec[9]  = '{1'b1, 6'd7,  1'b0, 1'b0, 4, 4, 0, 0};
    vec[10] = '{1'b1, 6'd8,  1'b0, 1'b0, 4, 4, 1, 1};
    vec[11] = '{1'b1, 6'd9,  1'b0, 1'b0, 4, 4, 1, 2};
    vec[12] = '{1'b0, 6'd0,  1'b0, 1'b1, 4, 4, 0, 0};
    vec[13] = '{1'b1, 6'd11, 1'b0, 1'b1, 4, 4, 0, 0};
    // push while full with a same-cycle pop, then drain showing 10 at tail
    vec[14] = '{1'b1, 6'd10, 1'b1, 1'b0, 4, 5, 0, 0};
    vec[15] = '{1'b0, 6'd0,  1'b1, 1'b0, 3, 6, 0, 0};
    vec[16] = '{1'b0, 6'd0,  1'b1, 1'b0, 2, 7, 0, 0};
    vec[17] = '{1'b0, 6'd0,  1'b1, 1'b0, 1, 10, 0, 0};
    vec[18] = '{1'b0, 6'd0,  1'b1, 1'b0, 0, 0, 0, 0};

    rst_n = 1'b0;
    winner_vld = 1'b0; winner_key = '0; winner_data = '0; out_rdy = 1'b0; ovf_clr = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      cycle(vec[i].vld, vec[i].key, dat_of(vec[i].key), vec[i].rdy, vec[i].clr);
      check($sformatf("vec%0d fill_cnt", i), 64'(o0_fill), 64'(vec[i].e_fill));
      check($sformatf("vec%0d out_key", i),  64'(o0_key),  64'(vec[i].e_key));
      check($sformatf("vec%0d out_data", i), 64'(o0_data),
            (vec[i].e_fill == 0) ? 64'd0 : 64'(dat_of(6'(vec[i].e_key))));
      check($sformatf("vec%0d overflow", i), 64'(o0_ovf),  64'(vec[i].e_ovf));
      check($sformatf("vec%0d drop_cnt", i), 64'(o0_drop), 64'(vec[i].e_drop));
      check($sformatf("vec%0d full", i),     64'(o0_full), 64'(vec[i].e_fill == DEP));
    end

    // duplicate suppression: 5,5,7,5 -> 5,7,5 on the dedup instance
    cycle(1'b1, 6'd5, 16'h0a05, 1'b0, 1'b0);
    cycle(1'b1, 6'd5, 16'h0b05, 1'b0, 1'b0);
    cycle(1'b1, 6'd7, 16'h0c07, 1'b0, 1'b0);
    cycle(1'b1, 6'd5, 16'h0d05, 1'b0, 1'b0);
    check("dup fill_cnt", 64'(o1_fill), 64'd3);
    check("dup drop_cnt", 64'(o1_drop), 64'd0);
    check("dup head key", 64'(o1_key),  64'd5);
    check("nodup fill_cnt", 64'(o0_fill), 64'd4);
    begin
      logic [KW-1:0] dup_keys [4];
      dup_keys = '{6'd7, 6'd5, 6'd0, 6'd0};
      for (int i = 0; i < 4; i++) begin
        cycle(1'b0, 6'd0, 16'h0, 1'b1, 1'b0);
        check($sformatf("dup drain%0d key", i), 64'(o1_key), 64'(dup_keys[i]));
      end
    end

    // a duplicate arriving while full is not a drop
    for (int i = 0; i < 4; i++) cycle(1'b1, 6'(40 + i), 16'h4000 + 16'(i), 1'b0, 1'b0);
    cycle(1'b1, 6'd43, 16'h4444, 1'b0, 1'b0);
    check("dup-full overflow", 64'(o1_ovf),  64'd0);
    check("dup-full drop_cnt", 64'(o1_drop), 64'd0);
    check("nodup-full drop_cnt", 64'(o0_drop), 64'd1);
    cycle(1'b0, 6'd0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 6'd0, 16'h0, 1'b1, 1'b0);

    // drop counter saturation
    for (int i = 0; i < 4; i++) cycle(1'b1, 6'(50 + i), 16'h5000 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b1, 6'(60 + (i % 4)), 16'(i), 1'b0, 1'b0);
    check("sat drop_cnt", 64'(o0_drop), 64'd255);
    check("sat overflow", 64'(o0_ovf),  64'd1);
    check("sat head key", 64'(o0_key),  64'd50);
    cycle(1'b0, 6'd0, 16'h0, 1'b0, 1'b1);
    check("sat cleared", 64'(o0_drop), 64'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 6'd0, 16'h0, 1'b1, 1'b0);

    // asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++) cycle(1'b1, 6'(i + 1), 16'h2000 + 16'(i), 1'b0, 1'b0);
    check("pre-reset fill_cnt", 64'(o0_fill), 64'd3);
    winner_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async rst out_vld",  64'(o0_vld),  64'd0);
    check("async rst fill_cnt", 64'(o0_fill), 64'd0);
    check("async rst out_key",  64'(o0_key),  64'd0);
    check_dut(0);
    check_dut(1);
    @(posedge clk);
    @(negedge clk);
    check_dut(0);
    rst_n = 1'b1;
    cycle(1'b1, 6'd9, 16'h0909, 1'b0, 1'b0);
    check("post-reset out_key",  64'(o0_key),  64'd9);
    check("post-reset fill_cnt", 64'(o0_fill), 64'd1);
    check("post-reset dup out_key", 64'(o1_key), 64'd9);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic v, r, c;
      v = ($urandom_range(0, 99) < 65);
      r = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 15) == 0);
      cycle(v, 6'($urandom_range(0, 3)), 16'($urandom), r, c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/winner_queue.md
WINNER_QUEUE -- requirements
Module: winner_queue

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 6, meaning width of winner key.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning width of winner data.
REQ-003 SHALL have parameter DEPTH, default 4, meaning queue entries; legal values are powers of 2 that are >=2.
REQ-004 SHALL have parameter DROP_DUP, default 0, meaning 1 = suppress a winner whose key equals the last accepted key.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-007 SHALL have port winner_vld, input, 1 bit, meaning a winner from the upstream binary aggregator is present this cycle; there is no backpressure.
REQ-008 SHALL have port winner_key, input, KEY_WIDTH bits, the winner key.
REQ-009 SHALL have port winner_data, input, DATA_WIDTH bits, the winner data.
REQ-010 SHALL have port out_vld, output, 1 bit, meaning the queue head is valid.
REQ-011 SHALL have port out_rdy, input, 1 bit, meaning the consumer accepts the head; a pop occurs when out_vld and out_rdy are both 1.
REQ-012 SHALL have port out_key, output, KEY_WIDTH bits, the head key.
REQ-013 SHALL have port out_data, output, DATA_WIDTH bits, the head data.
REQ-014 SHALL have port fill_cnt, output, $clog2(DEPTH)+1 bits, the current occupancy.
REQ-015 SHALL have port full, output, 1 bit, equal to (fill_cnt == DEPTH).
REQ-016 SHALL have port empty, output, 1 bit, equal to (fill_cnt == 0).
REQ-017 SHALL have port overflow, output, 1 bit, a sticky flag meaning a winner was lost to full.
REQ-018 SHALL have port drop_cnt, output, 8 bits, a saturating count of winners lost to full.
REQ-019 SHALL have port ovf_clr, input, 1 bit, a synchronous clear of overflow and drop_cnt.

Function
REQ-020 SHALL accept a winner on a cycle where winner_vld=1, it is not a suppressed duplicate, and (full=0 or a pop occurs in the same cycle).
REQ-021 SHALL write an accepted winner to mem[wr_ptr] and advance wr_ptr by 1 modulo DEPTH.
REQ-022 SHALL, on a pop, advance rd_ptr by 1 modulo DEPTH.
REQ-023 SHALL update fill_cnt as: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-024 SHALL drive out_vld = !empty, out_key = mem[rd_ptr] and out_data = mem[rd_ptr] combinationally, with out_key and out_data forced to 0 while empty.
REQ-025 SHALL have latency 1: a winner accepted at edge N gives out_vld=1 with its key and data after edge N, including when the queue was empty.
REQ-026 SHALL preserve order; entries leave strictly in acceptance order.
REQ-027 SHALL treat winner_vld=1 while full=1 with no same-cycle pop as a drop: the entry is not written, overflow is set to 1, and drop_cnt is incremented, saturating at 255.
REQ-028 SHALL accept winner_vld=1 while full=1 together with a same-cycle pop, with no drop; fill_cnt stays DEPTH.
REQ-029 SHALL, when DROP_DUP=1, hold last_key and last_key_vld, updated on every accepted push and cleared only by reset.
REQ-030 SHALL, when DROP_DUP=1, silently discard a winner with last_key_vld=1 and winner_key==last_key: no write, and no overflow or drop_cnt change.
REQ-031 SHALL evaluate duplicate suppression before the full check, so a duplicate arriving while full does not count as a drop.
REQ-032 SHALL make ovf_clr=1 clear overflow and drop_cnt next cycle, with ovf_clr taking priority over a same-cycle drop.
REQ-033 SHALL ignore out_rdy while empty.
REQ-034 SHALL have no reset on mem contents.

Reset
REQ-035 SHALL, while rst_n=0, immediately force wr_ptr=0, rd_ptr=0, fill_cnt=0, empty=1, full=0, out_vld=0, out_key=0, out_data=0, overflow=0, drop_cnt=0, last_key_vld=0, independent of clk.
REQ-036 SHALL discard all queued entries on reset asserted mid-operation; the first push after reset release appears as the first output.

Verification
REQ-037 SHALL have a bench case: DEPTH=4; push keys 1,2,3 on consecutive cycles with out_rdy=0 -> fill_cnt=3, then set out_rdy=1 -> keys 1,2,3 out in order, then empty=1.
REQ-038 SHALL have a bench case: fill to 4, then 2 more winners with out_rdy=0 -> full=1, overflow=1, drop_cnt=2, head key unchanged; then ovf_clr=1 -> overflow=0, drop_cnt=0.
REQ-039 SHALL have a bench case: full, winner_vld=1 and out_rdy=1 in the same cycle -> no drop, fill_cnt=4, new key at tail.
REQ-040 SHALL have a bench case: DROP_DUP=1; push keys 5,5,7,5 -> queue holds 5,7,5 and drop_cnt=0.
REQ-041 SHALL have a bench case: 300 winners pushed while full -> drop_cnt=255, saturated.
REQ-042 SHALL have a bench case: assert rst_n=0 mid-cycle with 3 queued entries -> out_vld=0 and fill_cnt=0 before the next clk edge; push key 9 after release -> out_key=9 one cycle later.
